// File: rtl/counter_capture_fifo.sv
// Input-capture stage: timestamps cap_in edges with {wrap_cnt, count}
// and buffers them in a small FIFO drained over valid/ready.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   count, done  counter value and terminal pulse from the counter
//   cap_in       asynchronous capture pin
//   edge_sel     00 off, 01 rise, 10 fall, 11 both
//   clr_ovf      pulse clearing overflow
//   out_valid    FIFO non-empty
//   out_ready    consumer accepts head entry
//   out_data     head entry {wrap_cnt, count}
//   level        stored entry count, 0..DEPTH
//   overflow     sticky, a capture was dropped
module counter_capture_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           count,
  input  logic                       done,
  input  logic                       cap_in,
  input  logic [1:0]                 edge_sel,
  input  logic                       clr_ovf,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH+7:0]           out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = WIDTH + 8;

  logic          sync1;
  logic          sync2;
  logic          sync3;
  logic [1:0]    arm_cnt;
  logic          armed;
  logic [7:0]    wrap_cnt;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] lvl;
  logic          rise;
  logic          fall;
  logic          detect;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  assign armed  = (arm_cnt == 2'd3);
  assign rise   = sync2 & ~sync3;
  assign fall   = ~sync2 & sync3;
  assign detect = armed &
                  ((edge_sel[0] & rise) |
                   (edge_sel[1] & fall));

  assign full = (lvl == LW'(DEPTH));
  assign pop  = out_valid & out_ready;
  // A same-cycle pop frees the slot a full FIFO needs.
  assign push = detect & (~full | pop);
  assign drop = detect & full & ~pop;

  assign out_valid = (lvl != '0);
  assign level     = lvl;
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync3   <= 1'b0;
      arm_cnt <= 2'd0;
    end else begin
      sync1 <= cap_in;
      sync2 <= sync1;
      sync3 <= sync2;
      if (!armed)
        arm_cnt <= arm_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wrap_cnt <= 8'd0;
    else if (done)
      wrap_cnt <= wrap_cnt + 8'd1;
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {wrap_cnt, count};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      lvl      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   lvl <= lvl + LW'(1);
        2'b01:   lvl <= lvl - LW'(1);
        default: lvl <= lvl;
      endcase
      if (drop)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_capture_fifo.sv
// Bench for counter_capture_fifo: directed plan plus random
// traffic against a queue-based reference model.
module tb_counter_capture_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [WIDTH-1:0]       count;
  logic                   done;
  logic                   cap_in;
  logic [1:0]             edge_sel;
  logic                   clr_ovf;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH+7:0]       out_data;
  logic [$clog2(DEPTH):0] level;
  logic                   overflow;

  counter_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .count(count), .done(done),
    .cap_in(cap_in), .edge_sel(edge_sel), .clr_ovf(clr_ovf),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [WIDTH+7:0] q[$];
  bit               hist[$];
  int               wrap;
  bit               ovf;
  int               edges;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    hist.delete();
    hist.push_back(1'b0);
    hist.push_back(1'b0);
    hist.push_back(1'b0);
    wrap  = 0;
    ovf   = 1'b0;
    edges = 0;
  endtask

  // Pin samples two and three edges back decide an edge;
  // nothing is captured until three edges after reset.
  task automatic model_edge();
    bit s2, s3, det, pp, drp;
    int n;
    n   = hist.size();
    s2  = hist[n-2];
    s3  = hist[n-3];
    det = (edges >= 3) &&
          ((edge_sel[0] && s2 && !s3) ||
           (edge_sel[1] && !s2 && s3));
    pp  = (q.size() > 0) && out_ready;
    drp = det && (q.size() == DEPTH) && !pp;
    if (pp) void'(q.pop_front());
    if (det && !drp) q.push_back({8'(wrap), count});
    if (drp) ovf = 1'b1;
    else if (clr_ovf) ovf = 1'b0;
    if (done) wrap = (wrap + 1) % 256;
    hist.push_back(cap_in);
    void'(hist.pop_front());
    edges++;
  endtask

  task automatic model_cmp();
    chk("valid", 32'(out_valid), 32'(q.size() != 0));
    chk("level", 32'(level), 32'(q.size()));
    chk("overflow", 32'(overflow), 32'(ovf));
    if (q.size() != 0)
      chk("data", 32'(out_data), 32'(q[0]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    model_cmp();
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic capture(logic [WIDTH-1:0] c, bit rdy,
                         bit clr);
    count  = c;
    cap_in = 1'b1;
    step();
    step();
    out_ready = rdy;
    clr_ovf   = clr;
    step();
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    cap_in    = 1'b0;
    steps(3);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    steps(DEPTH + 1);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    count     = '0;
    done      = 1'b0;
    cap_in    = 1'b0;
    edge_sel  = 2'b01;
    clr_ovf   = 1'b0;
    out_ready = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    release_reset();
    steps(5);

    // Rising capture
    count  = 8'h42;
    cap_in = 1'b1;
    step();
    step();
    chk("rise_early", 32'(out_valid), 32'd0);
    step();
    chk("rise_valid", 32'(out_valid), 32'd1);
    chk("rise_data", 32'(out_data), 32'h0042);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("rise_pop", 32'(level), 32'd0);
    cap_in = 1'b0;
    steps(3);

    // Wrap tag
    done = 1'b1;
    steps(3);
    done = 1'b0;
    capture(8'h05, 1'b0, 1'b0);
    chk("tag3", 32'(out_data), 32'h0305);
    drain();
    done = 1'b1;
    steps(256);
    done = 1'b0;
    capture(8'h07, 1'b0, 1'b0);
    chk("tag_wrap", 32'(out_data), 32'h0307);
    drain();

    // Overflow and ordering
    for (int i = 1; i <= 5; i++)
      capture(8'(i), 1'b0, 1'b0);
    chk("ovf_level", 32'(level), 32'd4);
    chk("ovf_set", 32'(overflow), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_order", 32'(out_data), 32'h0300 + 32'(i));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    for (int i = 6; i <= 9; i++)
      capture(8'(i), 1'b0, 1'b0);
    capture(8'h0A, 1'b0, 1'b1);
    chk("ovf_set_wins", 32'(overflow), 32'd1);

    // Full with simultaneous pop and push
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    capture(8'h0B, 1'b1, 1'b0);
    chk("full_pp_level", 32'(level), 32'd4);
    chk("full_pp_ovf", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    steps(3);
    out_ready = 1'b0;
    chk("full_pp_last", 32'(out_data), 32'h030B);
    drain();

    // Edge modes
    edge_sel = 2'b11;
    cap_in   = 1'b1;
    steps(5);
    cap_in = 1'b0;
    steps(5);
    chk("both_level", 32'(level), 32'd2);
    drain();
    edge_sel = 2'b10;
    cap_in   = 1'b1;
    steps(5);
    cap_in = 1'b0;
    for (int j = 0; j < 5; j++) begin
      count = 8'hA0 + 8'(j);
      step();
    end
    chk("fall_level", 32'(level), 32'd1);
    chk("fall_data", 32'(out_data), 32'h03A2);
    drain();
    edge_sel = 2'b00;
    cap_in   = 1'b1;
    steps(5);
    cap_in = 1'b0;
    steps(5);
    chk("off_level", 32'(level), 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) edge_sel = 2'($urandom);
      if ($urandom_range(2) == 0) cap_in = ~cap_in;
      count     = 8'($urandom);
      done      = ($urandom_range(7) == 0);
      out_ready = ($urandom_range(2) == 0);
      clr_ovf   = ($urandom_range(15) == 0);
      step();
    end
    done     = 1'b0;
    clr_ovf  = 1'b0;
    cap_in   = 1'b0;
    edge_sel = 2'b01;
    steps(4);
    drain();

    // Mid-run asynchronous reset
    capture(8'h11, 1'b0, 1'b0);
    capture(8'h22, 1'b0, 1'b0);
    chk("pre_rst_level", 32'(level), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    cap_in = 1'b1;
    release_reset();
    steps(10);
    chk("held_high", 32'(level), 32'd0);
    chk("held_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
